// File: rtl/alu_logic_seq_if.sv
// Handshake/operand bundle between the CPU control path and the multicycle logic unit.
// The master drives start/op/operands; the slave returns busy/done/result/zero.
interface alu_logic_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, zero
  );
endinterface

// File: rtl/alu_logic_seq.sv
// Multicycle bitwise logic unit: eight ops on WIDTH-bit operands, SLICE bits per clock,
// done WIDTH/SLICE clocks after the start edge; start is ignored while busy (no stall, no error).
module alu_logic_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input logic            clk,
  input logic            reset_n,
  alu_logic_seq_if.slave bus
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if ((WIDTH % SLICE) != 0) begin : g_bad_param
      $error("alu_logic_seq: WIDTH (%0d) must be a multiple of SLICE (%0d)", WIDTH, SLICE);
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_XOR   = 3'b010,
    OP_NAND  = 3'b011,
    OP_NOR   = 3'b100,
    OP_XNOR  = 3'b101,
    OP_ANDN  = 3'b110,
    OP_PASSA = 3'b111
  } op_t;

  state_t           state_q;
  state_t           state_d;
  op_t              op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] work_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             load;
  logic             step;
  logic             finish;
  logic [SLICE-1:0] slice_res;

  function automatic logic [SLICE-1:0] logic_op(input op_t        sel,
                                                input logic [SLICE-1:0] x,
                                                input logic [SLICE-1:0] y);
    logic [SLICE-1:0] r;
    r = x;
    case (sel)
      OP_AND:   r = x & y;
      OP_OR:    r = x | y;
      OP_XOR:   r = x ^ y;
      OP_NAND:  r = ~(x & y);
      OP_NOR:   r = ~(x | y);
      OP_XNOR:  r = ~(x ^ y);
      OP_ANDN:  r = x & ~y;
      OP_PASSA: r = x;
      default:  r = x;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == LAST) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands shift down one slice per step, so the live slice is always the low SLICE bits;
  // results enter at the top and the first slice lands at bit 0 after N steps.
  assign slice_res = logic_op(op_q, a_q[SLICE-1:0], b_q[SLICE-1:0]);
  assign work_d    = (work_q >> SLICE) | (WIDTH'(slice_res) << (WIDTH - SLICE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= OP_AND;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      if (load) begin
        op_q   <= op_t'(bus.op);
        a_q    <= bus.a;
        b_q    <= bus.b;
        work_q <= '0;
        cnt_q  <= '0;
      end else if (step) begin
        a_q    <= a_q >> SLICE;
        b_q    <= b_q >> SLICE;
        work_q <= work_d;
        cnt_q  <= finish ? '0 : cnt_q + 1'b1;
      end
      // Architectural outputs move only on completion, never showing partial slices.
      if (finish) begin
        result_q <= work_d;
        zero_q   <= (work_d == '0);
      end
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.zero   = zero_q;

endmodule

// File: tb/tb_alu_logic_seq.sv
// Scoreboard bench for alu_logic_seq: default 32/8, single-slice 32/32 and narrow 16/4 instances.
module tb_alu_logic_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  alu_logic_seq_if #(.WIDTH(32)) bus0 ();
  alu_logic_seq_if #(.WIDTH(32)) bus1 ();
  alu_logic_seq_if #(.WIDTH(16)) bus2 ();

  alu_logic_seq #(.WIDTH(32), .SLICE(8))  dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0.slave));
  alu_logic_seq #(.WIDTH(32), .SLICE(32)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1.slave));
  alu_logic_seq #(.WIDTH(16), .SLICE(4))  dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2.slave));

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int w);
    logic [31:0] r;
    logic [31:0] m;
    exp_t e;
    case (op)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = a ^ b;
      3'b011:  r = ~(a & b);
      3'b100:  r = ~(a | b);
      3'b101:  r = ~(a ^ b);
      3'b110:  r = a & ~b;
      default: r = a;
    endcase
    m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    e.res = r & m;
    e.z   = ((r & m) == 32'd0);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_done(input int which);
    case (which)
      0:       return bus0.done;
      1:       return bus1.done;
      default: return bus2.done;
    endcase
  endfunction

  // Bounded wait: returns edges elapsed, or 40 when done never arrived.
  task automatic wait_done(input int which, output int cyc);
    cyc = 0;
    while (get_done(which) !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    bus0.start = 1'b0; bus0.op = 3'b000; bus0.a = '0; bus0.b = '0;
    bus1.start = 1'b0; bus1.op = 3'b000; bus1.a = '0; bus1.b = '0;
    bus2.start = 1'b0; bus2.op = 3'b000; bus2.a = '0; bus2.b = '0;
    reset_n = 1'b0;
    repeat (3) tick();
    total++; if (bus0.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", bus0.busy); end
    total++; if (bus0.done !== 1'b0) begin bad++; $display("FAIL rst_done got %b want 0", bus0.done); end
    total++; if (bus0.result !== 32'h0) begin bad++; $display("FAIL rst_result got %h want 0", bus0.result); end
    total++; if (bus0.zero !== 1'b1) begin bad++; $display("FAIL rst_zero got %b want 1", bus0.zero); end
    total++; if (bus1.zero !== 1'b1 || bus1.busy !== 1'b0) begin bad++; $display("FAIL rst_dut1 got zero=%b busy=%b want 1/0", bus1.zero, bus1.busy); end
    total++; if (bus2.result !== 16'h0 || bus2.zero !== 1'b1) begin bad++; $display("FAIL rst_dut2 got %h/%b want 0000/1", bus2.result, bus2.zero); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_and();
    exp_t e;
    bus0.op = 3'b000; bus0.a = 32'hF0F0_F0F0; bus0.b = 32'hFF00_FF00; bus0.start = 1'b1;
    q0.push_back(model(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32));
    tick();
    bus0.start = 1'b0; bus0.op = 3'b111; bus0.a = 32'h1234_5678; bus0.b = 32'h0;
    for (int k = 1; k <= 4; k++) begin
      total++; if (bus0.busy !== 1'b1) begin bad++; $display("FAIL and_busy_%0d got %b want 1", k, bus0.busy); end
      total++; if (bus0.done !== 1'b0) begin bad++; $display("FAIL and_done_early_%0d got %b want 0", k, bus0.done); end
      total++; if (bus0.result !== 32'h0 || bus0.zero !== 1'b1) begin bad++; $display("FAIL and_hold_%0d got %h/%b want 0/1", k, bus0.result, bus0.zero); end
      tick();
    end
    total++; if (bus0.done !== 1'b1 || bus0.busy !== 1'b0) begin bad++; $display("FAIL and_done got done=%b busy=%b want 1/0", bus0.done, bus0.busy); end
    e = q0.pop_front();
    total++; if (bus0.result !== e.res || bus0.zero !== e.z) begin bad++; $display("FAIL and_result got %h/%b want %h/%b", bus0.result, bus0.zero, e.res, e.z); end
    tick();
    total++; if (bus0.done !== 1'b0) begin bad++; $display("FAIL and_pulse got %b want 0", bus0.done); end
  endtask

  task automatic test_xor_nand();
    exp_t e;
    int   c;
    for (int i = 0; i < 2; i++) begin
      bus0.op = (i == 0) ? 3'b010 : 3'b011;
      bus0.a = 32'h1234_5678; bus0.b = 32'h1234_5678; bus0.start = 1'b1;
      q0.push_back(model(bus0.op, 32'h1234_5678, 32'h1234_5678, 32));
      tick();
      bus0.start = 1'b0;
      wait_done(0, c);
      total++; if (c !== 4) begin bad++; $display("FAIL xn_latency_%0d got %0d want 4", i, c); end
      e = q0.pop_front();
      total++; if (bus0.result !== e.res || bus0.zero !== e.z) begin bad++; $display("FAIL xn_result_%0d got %h/%b want %h/%b", i, bus0.result, bus0.zero, e.res, e.z); end
      tick();
    end
  endtask

  task automatic test_all_ops();
    exp_t        e;
    int          c;
    logic [31:0] ra;
    logic [31:0] rb;
    for (int k = 0; k < 8; k++) begin
      ra = $urandom; rb = $urandom;
      bus0.op = 3'(k); bus0.a = ra; bus0.b = rb; bus0.start = 1'b1;
      q0.push_back(model(3'(k), ra, rb, 32));
      tick();
      bus0.start = 1'b0; bus0.a = ~ra; bus0.b = ~rb;
      wait_done(0, c);
      e = q0.pop_front();
      total++; if (c !== 4 || bus0.result !== e.res || bus0.zero !== e.z) begin bad++; $display("FAIL op_%0d got %h/%b in %0d want %h/%b in 4", k, bus0.result, bus0.zero, c, e.res, e.z); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bus0.op = 3'b001; bus0.a = 32'h0000_FFFF; bus0.b = 32'hFFFF_0000; bus0.start = 1'b1;
    q0.push_back(model(3'b001, 32'h0000_FFFF, 32'hFFFF_0000, 32));
    tick();
    bus0.op = 3'b110; bus0.a = 32'hFFFF_FFFF; bus0.b = 32'h0F0F_0F0F;
    for (int k = 1; k <= 4; k++) begin
      total++; if (bus0.busy !== 1'b1) begin bad++; $display("FAIL b2b_busy1_%0d got %b want 1", k, bus0.busy); end
      tick();
    end
    total++; if (bus0.done !== 1'b1) begin bad++; $display("FAIL b2b_done1 got %b want 1", bus0.done); end
    e = q0.pop_front();
    total++; if (bus0.result !== e.res) begin bad++; $display("FAIL b2b_result1 got %h want %h", bus0.result, e.res); end
    q0.push_back(model(3'b110, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 32));
    tick();
    for (int k = 0; k < 4; k++) begin
      total++; if (bus0.busy !== 1'b1 || bus0.done !== 1'b0) begin bad++; $display("FAIL b2b_busy2_%0d got busy=%b done=%b want 1/0", k, bus0.busy, bus0.done); end
      bus0.start = k[0]; bus0.op = 3'b000; bus0.a = $urandom; bus0.b = $urandom;
      tick();
    end
    bus0.start = 1'b0;
    total++; if (bus0.done !== 1'b1) begin bad++; $display("FAIL b2b_done2 got %b want 1", bus0.done); end
    e = q0.pop_front();
    total++; if (bus0.result !== e.res || bus0.zero !== e.z) begin bad++; $display("FAIL b2b_result2 got %h/%b want %h/%b", bus0.result, bus0.zero, e.res, e.z); end
    tick();
    total++; if (bus0.busy !== 1'b0 || bus0.done !== 1'b0) begin bad++; $display("FAIL b2b_idle got busy=%b done=%b want 0/0", bus0.busy, bus0.done); end
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    int   c;
    int   seen;
    bus0.op = 3'b010; bus0.a = 32'hAAAA_5555; bus0.b = 32'h0000_0001; bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    tick();
    tick();
    #3 reset_n = 1'b0;
    #1;
    total++; if (bus0.busy !== 1'b0 || bus0.done !== 1'b0) begin bad++; $display("FAIL mid_rst_ctl got busy=%b done=%b want 0/0", bus0.busy, bus0.done); end
    total++; if (bus0.result !== 32'h0 || bus0.zero !== 1'b1) begin bad++; $display("FAIL mid_rst_out got %h/%b want 0/1", bus0.result, bus0.zero); end
    tick();
    reset_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus0.done === 1'b1 || bus0.busy === 1'b1) seen++;
      tick();
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL mid_rst_quiet got %0d active cycles want 0", seen); end
    bus0.op = 3'b101; bus0.a = 32'h0F0F_0F0F; bus0.b = 32'h00FF_00FF; bus0.start = 1'b1;
    q0.push_back(model(3'b101, 32'h0F0F_0F0F, 32'h00FF_00FF, 32));
    tick();
    bus0.start = 1'b0;
    wait_done(0, c);
    e = q0.pop_front();
    total++; if (c !== 4 || bus0.result !== e.res || bus0.zero !== e.z) begin bad++; $display("FAIL mid_rst_fresh got %h/%b in %0d want %h/%b in 4", bus0.result, bus0.zero, c, e.res, e.z); end
    tick();
  endtask

  task automatic test_single_slice();
    exp_t e;
    int   c;
    bus1.op = 3'b111; bus1.a = 32'hDEAD_BEEF; bus1.b = 32'h1357_9BDF; bus1.start = 1'b1;
    q1.push_back(model(3'b111, 32'hDEAD_BEEF, 32'h1357_9BDF, 32));
    tick();
    bus1.start = 1'b0; bus1.a = 32'h0;
    total++; if (bus1.busy !== 1'b1) begin bad++; $display("FAIL n1_busy got %b want 1", bus1.busy); end
    wait_done(1, c);
    total++; if (c !== 1) begin bad++; $display("FAIL n1_latency got %0d want 1", c); end
    e = q1.pop_front();
    total++; if (bus1.result !== e.res || bus1.zero !== e.z) begin bad++; $display("FAIL n1_result got %h/%b want %h/%b", bus1.result, bus1.zero, e.res, e.z); end
    tick();
  endtask

  task automatic test_narrow();
    exp_t e;
    int   c;
    logic [15:0] na [2];
    logic [15:0] nb [2];
    logic [2:0]  nop [2];
    na[0] = 16'h00FF; nb[0] = 16'h0F00; nop[0] = 3'b100;
    na[1] = 16'h00FF; nb[1] = 16'hFF00; nop[1] = 3'b000;
    for (int i = 0; i < 2; i++) begin
      bus2.op = nop[i]; bus2.a = na[i]; bus2.b = nb[i]; bus2.start = 1'b1;
      q2.push_back(model(nop[i], {16'h0, na[i]}, {16'h0, nb[i]}, 16));
      tick();
      bus2.start = 1'b0; bus2.a = 16'hFFFF;
      wait_done(2, c);
      e = q2.pop_front();
      total++; if (c !== 4) begin bad++; $display("FAIL w16_latency_%0d got %0d want 4", i, c); end
      total++; if (bus2.result !== e.res[15:0] || bus2.zero !== e.z) begin bad++; $display("FAIL w16_result_%0d got %h/%b want %h/%b", i, bus2.result, bus2.zero, e.res[15:0], e.z); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_and();
    test_xor_nand();
    test_all_ops();
    test_back_to_back();
    test_reset_mid_run();
    test_single_slice();
    test_narrow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
